data_mem_responder: RTL



---
 rtl/data_mem_responder.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/data_mem_responder.sv
// Word-addressed data-memory responder with programmable wait states and byte-masked stores.
// Optional DATA_MEM_STATS_EN adds saturating load/store/error handshake counters.
module data_mem_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
`ifdef DATA_MEM_STATS_EN
  ,
  output logic [15:0] stat_rd_cnt,
  output logic [15:0] stat_wr_cnt,
  output logic [15:0] stat_err_cnt
`endif
);

  localparam int AW = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t      state_reg, state_next;
  logic [3:0]  cnt_reg, cnt_next;
  logic        we_reg;
  logic [31:0] addr_reg;
  logic [31:0] wdata_reg;
  logic [3:0]  be_reg;
  logic        err_reg, err_next;
  logic        rd_ok_reg, rd_ok_next;
  logic [31:0] mem_q_reg;
  logic [31:0] mem [DEPTH_WORDS];

  logic [AW-1:0] index;
  logic          addr_err;
  logic          access;
  logic          req_fire;
  logic          rsp_fire;

  assign index    = addr_reg[AW+1:2];
  assign addr_err = (addr_reg[1:0] != 2'b00) || ((addr_reg >> (AW + 2)) != 32'd0);
  assign access   = (state_reg == WAIT) && (cnt_reg == 4'd0);
  assign req_fire = req_valid && req_ready;
  assign rsp_fire = rsp_valid && rsp_ready;

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    err_next   = err_reg;
    rd_ok_next = rd_ok_reg;
    req_ready  = 1'b0;
    rsp_valid  = 1'b0;
    case (state_reg)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          state_next = WAIT;
          cnt_next   = 4'(WAIT_CYCLES);
        end
      end
      WAIT: begin
        if (cnt_reg != 4'd0) begin
          cnt_next = cnt_reg - 4'd1;
        end else begin
          state_next = RESP;
          err_next   = addr_err;
          rd_ok_next = !we_reg && !addr_err;
        end
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          state_next = IDLE;
          err_next   = 1'b0;
          rd_ok_next = 1'b0;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
      cnt_reg   <= 4'd0;
      err_reg   <= 1'b0;
      rd_ok_reg <= 1'b0;
      we_reg    <= 1'b0;
      addr_reg  <= 32'd0;
      wdata_reg <= 32'd0;
      be_reg    <= 4'd0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      err_reg   <= err_next;
      rd_ok_reg <= rd_ok_next;
      if (req_fire) begin
        we_reg    <= req_we;
        addr_reg  <= req_addr;
        wdata_reg <= req_wdata;
        be_reg    <= req_be;
      end
    end
  end

  // Array port: read-first, enabled only on the cycle that leaves WAIT so the
  // read word and any store commit line up with the transition to RESP.
  always_ff @(posedge clk) begin
    if (access) begin
      mem_q_reg <= mem[index];
      if (we_reg && !addr_err) begin
        for (int b = 0; b < 4; b++) begin
          if (be_reg[b]) mem[index][8*b +: 8] <= wdata_reg[8*b +: 8];
        end
      end
    end
  end

  assign rsp_rdata = rd_ok_reg ? mem_q_reg : 32'd0;
  assign rsp_err   = err_reg;

`ifdef DATA_MEM_STATS_EN
  logic [15:0] rd_cnt_reg, wr_cnt_reg, err_cnt_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_cnt_reg  <= 16'd0;
      wr_cnt_reg  <= 16'd0;
      err_cnt_reg <= 16'd0;
    end else if (rsp_fire) begin
      if (we_reg) begin
        if (wr_cnt_reg != 16'hFFFF) wr_cnt_reg <= wr_cnt_reg + 16'd1;
      end else begin
        if (rd_cnt_reg != 16'hFFFF) rd_cnt_reg <= rd_cnt_reg + 16'd1;
      end
      if (err_reg && err_cnt_reg != 16'hFFFF) err_cnt_reg <= err_cnt_reg + 16'd1;
    end
  end

  assign stat_rd_cnt  = rd_cnt_reg;
  assign stat_wr_cnt  = wr_cnt_reg;
  assign stat_err_cnt = err_cnt_reg;
`endif

endmodule
